// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
// Walks LOAD -> {CHECK [-> ARITH] -> SHIFT} x WIDTH -> DONE and issues the
// A/Q/M/Q[-1] strobes from the Booth pair {q0, qm1}.
// Optional feature macro: BOOTH_ABORT_EN adds an abort input that returns the
// FSM to IDLE from any busy state without a done pulse.
module booth_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             clr_qm1,
  output logic             ld_a_alu,
  output logic             addsub,
  output logic             sft,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef BOOTH_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ARITH = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count_n;
  logic             addsub_n;
  logic             abort_i;

`ifdef BOOTH_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Next-state, iteration counter and ALU-select latch.
  always_comb begin
    state_n  = S_IDLE;
    count_n  = count;
    addsub_n = addsub;
    case (state)
      S_IDLE:  state_n = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        state_n = S_CHECK;
        count_n = CNT_W'(WIDTH);
      end
      S_CHECK: begin
        case ({q0, qm1})
          2'b10: begin
            state_n  = S_ARITH;
            addsub_n = 1'b1;
          end
          2'b01: begin
            state_n  = S_ARITH;
            addsub_n = 1'b0;
          end
          default: state_n = S_SHIFT;
        endcase
      end
      S_ARITH: state_n = S_SHIFT;
      S_SHIFT: begin
        // count <= 1 exits, so the decrement can never wrap past zero
        if (count <= CNT_W'(1)) begin
          state_n = S_DONE;
          count_n = '0;
        end else begin
          state_n = S_CHECK;
          count_n = count - CNT_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        count_n = '0;
      end
    endcase
    if (abort_i && (state != S_IDLE)) begin
      state_n = S_IDLE;
      count_n = '0;
    end
  end

  // State register; strobes are registered decodes of the state being entered,
  // so they are glitch-free and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      addsub   <= 1'b0;
      ld_m     <= 1'b0;
      ld_q     <= 1'b0;
      clr_a    <= 1'b0;
      clr_qm1  <= 1'b0;
      ld_a_alu <= 1'b0;
      sft      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      addsub   <= addsub_n;
      ld_m     <= (state_n == S_LOAD);
      ld_q     <= (state_n == S_LOAD);
      clr_a    <= (state_n == S_LOAD);
      clr_qm1  <= (state_n == S_LOAD);
      ld_a_alu <= (state_n == S_ARITH);
      sft      <= (state_n == S_SHIFT);
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed bench for booth_ctrl paired with a behavioural
// A/Q/M/Q[-1] datapath. Expected products and latencies are hand-computed.
module tb_booth_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             q0, qm1;
  logic             ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, addsub, sft, busy, done;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_in = '0, q_in = '0;
  logic [16:0] a_r = '0;  // one guard bit so A-M cannot overflow for M = -2^15
  logic [15:0] q_r = '0, m_r = '0;
  logic        qm1_r = 1'b0;

  always #5 clk = ~clk;

  booth_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .qm1(qm1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .clr_qm1(clr_qm1),
    .ld_a_alu(ld_a_alu), .addsub(addsub), .sft(sft), .busy(busy),
    .done(done), .count(count)
`ifdef BOOTH_ABORT_EN
    , .abort(abort)
`endif
  );

  assign q0  = q_r[0];
  assign qm1 = qm1_r;

  // Behavioural datapath driven by the controller strobes
  always @(posedge clk) begin
    if (ld_m)    m_r   <= m_in;
    if (ld_q)    q_r   <= q_in;
    if (clr_a)   a_r   <= '0;
    if (clr_qm1) qm1_r <= 1'b0;
    if (ld_a_alu) a_r  <= addsub ? (a_r - {m_r[15], m_r}) : (a_r + {m_r[15], m_r});
    if (sft) {a_r, q_r, qm1_r} <= {a_r[16], a_r, q_r};
  end

  // Runs one multiply; edge 0 is the edge that samples start.
  task automatic do_mul(input logic [15:0] mv, input logic [15:0] qv,
                        output int done_e, output int n_sft, output int n_arith,
                        output logic alt_ok, output logic [31:0] prod,
                        output logic load_ok, output logic [CNT_W-1:0] cnt_first,
                        output logic [CNT_W-1:0] cnt_done, output logic busy_at_done,
                        output logic busy_after);
    logic exp_alt;
    done_e = -1; n_sft = 0; n_arith = 0; alt_ok = 1'b1; exp_alt = 1'b1;
    prod = '0; cnt_first = '0; cnt_done = '1; busy_at_done = 1'b0;
    @(negedge clk);
    m_in = mv; q_in = qv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_ok = ld_m && ld_q && clr_a && clr_qm1 && busy && !sft && !ld_a_alu && !done;
    for (int e = 1; e <= 200 && done_e < 0; e++) begin
      @(posedge clk); #1;
      if (e == 1) cnt_first = count;
      if (sft) n_sft++;
      if (ld_a_alu) begin
        if (addsub !== exp_alt) alt_ok = 1'b0;
        exp_alt = ~exp_alt;
        n_arith++;
      end
      if (done) begin
        done_e = e;
        prod = {a_r[15:0], q_r};
        cnt_done = count;
        busy_at_done = busy;
      end
    end
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, addsub, sft, busy, done} !== 9'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=000000000",
               {ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, addsub, sft, busy, done});
    end
    checks++;
    if (count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_basic(input string nm, input logic [15:0] mv, input logic [15:0] qv,
                            input logic [31:0] exp_prod, input int exp_done, input int exp_arith,
                            input logic chk_alt);
    int de, ns, na;
    logic ao, lo, bd, ba;
    logic [31:0] pr;
    logic [CNT_W-1:0] cf, cd;
    do_mul(mv, qv, de, ns, na, ao, pr, lo, cf, cd, bd, ba);
    checks++;
    if (de !== exp_done) begin
      failures++;
      $display("FAIL %s done_edge got=%0d want=%0d", nm, de, exp_done);
    end
    checks++;
    if (pr !== exp_prod) begin
      failures++;
      $display("FAIL %s product got=%h want=%h", nm, pr, exp_prod);
    end
    checks++;
    if (ns !== WIDTH) begin
      failures++;
      $display("FAIL %s sft_pulses got=%0d want=%0d", nm, ns, WIDTH);
    end
    checks++;
    if (na !== exp_arith) begin
      failures++;
      $display("FAIL %s arith_visits got=%0d want=%0d", nm, na, exp_arith);
    end
    checks++;
    if (lo !== 1'b1) begin
      failures++;
      $display("FAIL %s load_strobes got=%b want=1", nm, lo);
    end
    checks++;
    if (cf !== CNT_W'(WIDTH) || cd !== '0) begin
      failures++;
      $display("FAIL %s count first=%0d done=%0d want 16/0", nm, cf, cd);
    end
    checks++;
    if (bd !== 1'b1 || ba !== 1'b0) begin
      failures++;
      $display("FAIL %s busy at_done=%b after=%b want 1/0", nm, bd, ba);
    end
    if (chk_alt) begin
      checks++;
      if (ao !== 1'b1) begin
        failures++;
        $display("FAIL %s addsub_alternation got=%b want=1", nm, ao);
      end
    end
  endtask

  task automatic test_reset_mid_arith();
    int guard;
    int seen_done;
    guard = 0;
    seen_done = 0;
    @(negedge clk);
    m_in = 16'h8000; q_in = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!ld_a_alu && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (ld_a_alu !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid reach_arith got=%b want=1", ld_a_alu);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, addsub, sft, busy, done} !== 9'b0 || count !== '0) begin
      failures++;
      $display("FAIL rst_mid outputs got=%b count=%0d want=0 0",
               {ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, addsub, sft, busy, done}, count);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL rst_mid spurious_activity got=%0d want=0", seen_done);
    end
    test_basic("after_rst", 16'h0007, 16'hFFFF, 32'hFFFF_FFF9, 34, 1, 1'b0);
  endtask

  // start stays high: second op starts only after the IDLE cycle
  task automatic test_back_to_back();
    int d1, d2, idle_cnt, idle_e;
    logic [31:0] p1, p2;
    logic ovl;
    d1 = -1; d2 = -1; idle_cnt = 0; idle_e = -1; ovl = 1'b0; p1 = '0; p2 = '0;
    @(negedge clk);
    m_in = 16'h0003; q_in = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 72; e++) begin
      @(posedge clk); #1;
      if (done && busy) ovl = 1'b1;
      if (done && d1 < 0) begin d1 = e; p1 = {a_r[15:0], q_r}; end
      else if (done) begin d2 = e; p2 = {a_r[15:0], q_r}; end
      if (!busy) begin idle_cnt++; idle_e = e; end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 35 || d2 !== 72) begin
      failures++;
      $display("FAIL b2b done_edges got=%0d,%0d want=35,72", d1, d2);
    end
    checks++;
    if (idle_cnt !== 1 || idle_e !== 36) begin
      failures++;
      $display("FAIL b2b idle_cycles got=%0d at=%0d want=1 at 36", idle_cnt, idle_e);
    end
    checks++;
    if (p1 !== 32'd6 || p2 !== 32'd6 || ovl !== 1'b1) begin
      failures++;
      $display("FAIL b2b products got=%h,%h overlap=%b want=6,6,1", p1, p2, ovl);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b settle_idle got=%b want=0", busy);
    end
  endtask

`ifdef BOOTH_ABORT_EN
  task automatic test_abort();
    int ns, guard, spurious;
    ns = 0; guard = 0; spurious = 0;
    @(negedge clk);
    m_in = 16'd5; q_in = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (ns < 5 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
      if (sft) ns++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, sft, busy, done} !== 8'b0 || count !== '0) begin
      failures++;
      $display("FAIL abort outputs got=%b count=%0d want=0 0",
               {ld_m, ld_q, clr_a, clr_qm1, ld_a_alu, sft, busy, done}, count);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL abort no_done got=%0d want=0", spurious);
    end
    test_basic("after_abort", 16'd5, 16'd3, 32'd15, 35, 2, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic("m3_q0", 16'h0003, 16'h0000, 32'h0000_0000, 33, 0, 1'b0);
    test_basic("m7_qneg1", 16'h0007, 16'hFFFF, 32'hFFFF_FFF9, 34, 1, 1'b0);
    test_basic("m8000_q5555", 16'h8000, 16'h5555, 32'hD555_8000, 49, 16, 1'b1);
    test_reset_mid_arith();
    test_back_to_back();
`ifdef BOOTH_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. Sits directly upstream of the A/Q/M shift registers and the add/subtract unit. Issues their load, clear, shift and ALU-select strobes from the Booth bit pair {Q[0], Q[-1]}, and counts iterations. Offers a start/busy/done handshake to the surrounding system.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; also the number of Booth iterations.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- q0  input  1  Q register bit 0, from the datapath.
- qm1  input  1  Q[-1] flop value, from the datapath.
- ld_m  output  1  load multiplicand register.
- ld_q  output  1  load multiplier register.
- clr_a  output  1  clear accumulator A.
- clr_qm1  output  1  clear Q[-1] flop.
- ld_a_alu  output  1  load A from the add/subtract result.
- addsub  output  1  ALU select: 0 = A+M, 1 = A−M. Meaningful only while ld_a_alu = 1.
- sft  output  1  arithmetic right shift of {A, Q, Q[-1]} together.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- count  output  CNT_W  remaining iterations, for debug.
- abort  input  1  present only with BOOTH_ABORT_EN (see Configuration).

## Operation
- Moore FSM with states IDLE, LOAD, CHECK, ARITH, SHIFT, DONE. All strobes are decoded from the registered state only.
- IDLE: all strobes low. If start = 1, go to LOAD.
- LOAD:
  - Assert ld_m, ld_q, clr_a and clr_qm1.
  - Load count with WIDTH.
  - Go to CHECK.
- CHECK: no strobes. Latch the pair {q0, qm1}:
  - 10 → ARITH with addsub = 1.
  - 01 → ARITH with addsub = 0.
  - 00 or 11 → SHIFT.
- ARITH: assert ld_a_alu. addsub holds the value latched in CHECK. Go to SHIFT.
- SHIFT:
  - Assert sft.
  - Decrement count.
  - If count was 1 (becomes 0), go to DONE; otherwise go to CHECK.
- DONE: assert done for one cycle, then go to IDLE.
- start is ignored in every state except IDLE. There is no queuing.
- The counter never wraps: it is decremented only in SHIFT, and SHIFT always exits to DONE when count reaches 0.
- Undefined or illegal state encodings recover to IDLE on the next clock.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE
  - count = 0
  - latched addsub = 0
  - every output = 0
- Asserting reset mid-operation aborts immediately; done is not pulsed.
- Latency, counting edges after the edge that samples start (edge 0):
  - LOAD occupies cycle 1.
  - Each iteration takes 2 cycles (CHECK + SHIFT), or 3 cycles when ARITH is needed.
  - done is high in the cycle after edge 2·WIDTH + 1 + N_arith, where N_arith is the number of ARITH visits.
- busy rises in the cycle after the start edge. It falls in the cycle after DONE, so busy and done overlap for one cycle.
- A new start may be sampled in the first IDLE cycle after DONE.
- q0 and qm1 must be stable in CHECK. The datapath updates them only on ld_q, clr_qm1 and sft edges, so this holds by construction.

## Configuration
- BOOTH_ABORT_EN defined:
  - The abort input exists.
  - abort = 1 in any state except IDLE sends the FSM to IDLE on the next edge.
  - count is forced to 0 and no strobes are issued in that cycle; done is not pulsed.
  - abort in IDLE has no effect; abort takes priority over start.
- BOOTH_ABORT_EN undefined: the abort port is absent and the FSM always runs to DONE.

## Test plan
The bench pairs the controller with a behavioural A/Q/M/Q[-1] datapath. WIDTH = 16.
- Reset mid-ARITH: drive rst_n low asynchronously between edges → all outputs 0 immediately; no done pulse; the next start runs a full multiply correctly.
- M = 3, Q = 0 → no ARITH visits; done in the cycle after edge 33; product 0; exactly 16 sft pulses.
- M = 7, Q = 0xFFFF (−1) → one ARITH (subtract, at bit 0); done after edge 34; product 0xFFFFFFF9 (−7).
- M = 0x8000, Q = 0x5555 → 16 ARITH visits with alternating addsub 1,0,1,0…; done after edge 49; product matches the signed reference.
- start held high through the whole operation and through DONE → exactly one operation per IDLE visit; busy and done overlap for one cycle; count runs 16→0.
- With BOOTH_ABORT_EN: pulse abort in SHIFT of iteration 5 → IDLE at the next edge, count = 0, no done; a subsequent start gives the correct product.
